// File: rtl/booth_pp_accumulator_pkg.sv
// Shared constants for the radix-4 Booth multiply path: select codes,
// default widths and the accumulator FSM state encodings.
package booth_pp_accumulator_pkg;

    // Default operand and derived widths
    localparam int DIN_W_DEF  = 16;
    localparam int PP_W_DEF   = DIN_W_DEF + 1;
    localparam int PROD_W_DEF = 2 * DIN_W_DEF;

    // Booth digit select codes produced by the partial-product generator
    localparam logic [2:0] BOOTH_m2A = 3'd1;
    localparam logic [2:0] BOOTH_mA  = 3'd2;
    localparam logic [2:0] BOOTH_0   = 3'd3;
    localparam logic [2:0] BOOTH_pA  = 3'd4;
    localparam logic [2:0] BOOTH_p2A = 3'd5;

    // Accumulator FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/booth_pp_weight.sv
// Turns one Booth partial-product beat into its weighted product-width term:
// sign-extend the body, add the negation correction bit, then shift left by
// two bits per digit position.
module booth_pp_weight
    import booth_pp_accumulator_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEF,
    parameter int IDX_W  = 3
) (
    input  logic [DIN_W:0]     pp_dout,
    input  logic               pp_sign,
    input  logic [IDX_W-1:0]   idx,
    output logic [2*DIN_W-1:0] weighted
);

    localparam int PP_W   = DIN_W + 1;
    localparam int PROD_W = 2 * DIN_W;

    logic [PROD_W-1:0] ext_s;
    logic [PROD_W-1:0] val_s;
    logic [IDX_W:0]    shamt_s;

    // Sign-extend, apply the +1 correction and weight by digit position (mod 2^PROD_W)
    always_comb begin
        ext_s    = {{(PROD_W - PP_W){pp_dout[PP_W-1]}}, pp_dout};
        val_s    = ext_s + {{(PROD_W - 1){1'b0}}, pp_sign};
        shamt_s  = {idx, 1'b0};
        weighted = val_s << shamt_s;
    end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential consumer of the radix-4 Booth partial-product stream. Accepts
// one beat per cycle, accumulates NUM_PP weighted beats into a signed
// product and hands it downstream over a valid/ready handshake. Stream
// protocol violations produce a single-cycle err pulse.
module booth_pp_accumulator
    import booth_pp_accumulator_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pp_valid,
    output logic                 pp_ready,
    input  logic [DIN_W:0]       pp_dout,
    input  logic                 pp_sign,
    input  logic                 pp_first,
    output logic                 prod_valid,
    input  logic                 prod_ready,
    output logic [2*DIN_W-1:0]   prod,
    output logic                 err
);

    localparam int PROD_W = 2 * DIN_W;
    localparam int NUM_PP = DIN_W / 2;
    // Keep the index at least one bit wide so NUM_PP == 1 still elaborates
    localparam int IDX_W  = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PP - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [PROD_W-1:0] acc_q,   acc_d;
    logic              err_q,   err_d;

    logic              pp_fire_s;
    logic [IDX_W-1:0]  w_idx_s;
    logic [PROD_W-1:0] w_val_s;

    assign pp_ready   = (state_q != ST_DONE);
    assign prod_valid = (state_q == ST_DONE);
    assign prod       = acc_q;
    assign err        = err_q;
    assign pp_fire_s  = pp_valid && pp_ready;

    // A first-marked beat always restarts at digit 0, whatever idx currently holds
    assign w_idx_s = pp_first ? IDX_ZERO : idx_q;

    booth_pp_weight #(
        .DIN_W (DIN_W),
        .IDX_W (IDX_W)
    ) u_weight (
        .pp_dout  (pp_dout),
        .pp_sign  (pp_sign),
        .idx      (w_idx_s),
        .weighted (w_val_s)
    );

    // Next-state, index, accumulator and error-pulse computation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pp_fire_s && pp_first) begin
                    acc_d = w_val_s;
                    if (NUM_PP == 1) begin
                        idx_d   = IDX_ZERO;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = IDX_ONE;
                        state_d = ST_ACCUM;
                    end
                end else if (pp_fire_s) begin
                    // Orphan beat with no product start: drop it and flag
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (pp_fire_s && pp_first) begin
                    // Restart: discard the partial sum and begin a new product
                    err_d   = 1'b1;
                    acc_d   = w_val_s;
                    idx_d   = IDX_ONE;
                    state_d = ST_ACCUM;
                end else if (pp_fire_s) begin
                    acc_d = acc_q + w_val_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = IDX_ZERO;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (prod_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = IDX_ZERO;
                acc_d   = {PROD_W{1'b0}};
            end
        endcase
    end

    // State registers with synchronous, highest-priority reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_ZERO;
            acc_q   <= {PROD_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed scoreboard bench for booth_pp_accumulator: the stimulus process
// pushes hand-computed products into a queue and a monitor pops and compares
// whenever a product is handed off.
module tb_booth_pp_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        pp_valid;
    logic        pp_ready;
    logic [16:0] pp_dout;
    logic        pp_sign;
    logic        pp_first;
    logic        prod_valid;
    logic        prod_ready;
    logic [31:0] prod;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Directed vectors: 0 = 3*5, 1 = (-1)*(-1), 2 = 0x8000*0x8000
    logic [16:0] vd[3][8];
    logic        vs[3][8];
    logic [31:0] vp[3];

    always #5 clk = ~clk;

    booth_pp_accumulator #(.DIN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pp_valid   (pp_valid),
        .pp_ready   (pp_ready),
        .pp_dout    (pp_dout),
        .pp_sign    (pp_sign),
        .pp_first   (pp_first),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one beat, wait (bounded) for acceptance, then check err and prod_valid
    task automatic send_beat(input logic [16:0] d, input logic s, input logic f,
                             input logic e_err, input logic e_pv, input string tag);
        int n;
        @(negedge clk);
        pp_valid = 1'b1;
        pp_dout  = d;
        pp_sign  = s;
        pp_first = f;
        n = 0;
        while (!pp_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!pp_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept timeout: pp_ready stayed 0 expected 1", tag);
            pp_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        pp_valid = 1'b0;
        chk({tag, " err"}, 32'(err), 32'(e_err));
        chk({tag, " prod_valid"}, 32'(prod_valid), 32'(e_pv));
    endtask

    // Send the first nb beats of vector k; a complete stream queues its product
    task automatic send_vec(input int k, input int nb, input logic first_err, input string tag);
        for (int i = 0; i < nb; i++) begin
            send_beat(vd[k][i], vs[k][i], (i == 0), (i == 0) ? first_err : 1'b0,
                      (i == 7), tag);
        end
        if (nb == 8) begin
            exp_q.push_back(vp[k]);
        end
    endtask

    // Monitor: every product handoff is compared against the scoreboard head
    always @(negedge clk) begin
        if (!rst && prod_valid && prod_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected product: got 0x%08h expected none", prod);
            end else begin
                chk("product", prod, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                vd[k][i] = 17'h00000;
                vs[k][i] = 1'b0;
            end
        end
        vd[0][0] = 17'h00003;
        vd[0][1] = 17'h00003;
        vp[0]    = 32'h0000000F;
        vs[1][0] = 1'b1;
        vp[1]    = 32'h00000001;
        vd[2][7] = 17'h0FFFF;
        vs[2][7] = 1'b1;
        vp[2]    = 32'h40000000;

        rst        = 1'b1;
        pp_valid   = 1'b0;
        pp_dout    = 17'h00000;
        pp_sign    = 1'b0;
        pp_first   = 1'b0;
        prod_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset pp_ready", 32'(pp_ready), 32'd1);
        chk("reset prod_valid", 32'(prod_valid), 32'd0);
        chk("reset prod", prod, 32'd0);
        chk("reset err", 32'(err), 32'd0);

        // Basic products
        send_vec(0, 8, 1'b0, "x3y5");
        send_vec(1, 8, 1'b0, "m1m1");
        send_vec(2, 8, 1'b0, "min");

        // Backpressure: product must hold and no beat accepted in DONE
        @(posedge clk);
        #1;
        prod_ready = 1'b0;
        send_vec(0, 8, 1'b0, "bp");
        repeat (5) begin
            @(negedge clk);
            chk("bp hold prod", prod, 32'h0000000F);
            chk("bp hold prod_valid", 32'(prod_valid), 32'd1);
            chk("bp hold pp_ready", 32'(pp_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        prod_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release pp_ready", 32'(pp_ready), 32'd1);
        chk("bp release prod_valid", 32'(prod_valid), 32'd0);

        // Protocol errors: orphan beat in IDLE, then restart at beat 3
        send_beat(17'h00005, 1'b0, 1'b0, 1'b1, 1'b0, "idle_orphan");
        @(posedge clk);
        #1;
        chk("orphan err one cycle", 32'(err), 32'd0);
        chk("orphan stays idle", 32'(pp_ready), 32'd1);
        send_vec(0, 3, 1'b0, "partial");
        send_vec(0, 8, 1'b1, "restart");

        // Mid-product reset
        @(posedge clk);
        #1;
        send_vec(1, 4, 1'b0, "pre_rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst prod", prod, 32'd0);
        chk("rst prod_valid", 32'(prod_valid), 32'd0);
        chk("rst pp_ready", 32'(pp_ready), 32'd1);
        chk("rst err", 32'(err), 32'd0);
        send_vec(1, 8, 1'b0, "post_rst");

        // Drain scoreboard
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_pp_accumulator.md
Name: booth_pp_accumulator

Overview:
Sequential consumer for the radix-4 Booth partial-product stream. It takes one partial product per accepted beat, as a 17-bit ones'-complement-style body plus a sign/increment bit. It weights each beat by its digit position and accumulates the eight beats into the full signed product. It sits between the Booth partial-product generator and the ALU result mux, and offers valid/ready handshakes on both sides.

Parameters:
DIN_W, 16, multiplicand/multiplier width in bits; must be even.
PP_W, DIN_W+1, partial-product body width; derived, not overridable.
NUM_PP, DIN_W/2, partial products per product (8 at default).
PROD_W, 2*DIN_W, product width (32 at default).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
pp_valid  input  1  partial-product beat valid
pp_ready  output  1  block can accept a beat this cycle
pp_dout  input  PP_W  partial-product body (17 bits)
pp_sign  input  1  +1 correction bit for negated partial products
pp_first  input  1  marks digit index 0 of a new product
prod_valid  output  1  product available
prod_ready  input  1  downstream accepts product
prod  output  PROD_W  signed product, two's complement
err  output  1  one-cycle pulse on stream protocol violation

Behaviour:
- Transfer on a side occurs when valid&&ready at the rising clk edge.
- Beat value: V = sext_PROD_W(pp_dout) + pp_sign. Contribution: V << (2*idx), where idx is the digit index 0..NUM_PP-1. All arithmetic is mod 2^PROD_W; overflow is discarded.
- Registers: state, idx (log2 NUM_PP bits), acc (PROD_W bits), err.
- FSM states IDLE, ACCUM, DONE. pp_ready=1 in IDLE and ACCUM, 0 in DONE. prod_valid=1 only in DONE. prod=acc at all times.
- IDLE, beat with pp_first=1: acc<=V, idx<=1, go ACCUM. If NUM_PP==1, go DONE instead.
- IDLE, beat with pp_first=0: beat is consumed and dropped; err pulses the next cycle; stay IDLE.
- ACCUM, beat with pp_first=0: acc<=acc+(V<<2*idx), idx<=idx+1. If idx==NUM_PP-1, go DONE, idx<=0.
- ACCUM, beat with pp_first=1: err pulses; the in-progress product is discarded; acc<=V, idx<=1; stay ACCUM. This is a restart, not an abort.
- DONE: prod held stable while prod_ready=0. When prod_ready=1, go IDLE the next cycle. No beat is accepted in DONE, even if prod_ready=1 that cycle.
- Latency: prod_valid rises on the cycle after the NUM_PP-th beat is accepted. Minimum period is NUM_PP+1 cycles per product.
- err is registered, high for exactly one cycle per violation; it is 0 in all other cycles.
- rst (synchronous, highest priority, may occur mid-product): state<=IDLE, idx<=0, acc<=0, err<=0. After reset: pp_ready=1, prod_valid=0, prod=0, err=0. The partial product is lost; no err is raised.
- pp_dout/pp_sign/pp_first are ignored when pp_valid=0. prod_ready is ignored outside DONE.

Decomposition:
- Shared package: Booth select codes (BOOTH_m2A=1, BOOTH_mA=2, BOOTH_0=3, BOOTH_pA=4, BOOTH_p2A=5), DIN_W/PP_W/PROD_W defaults, FSM state encodings (IDLE=0, ACCUM=1, DONE=2).
- One combinational sub-module, booth_pp_weight: inputs pp_dout, pp_sign, idx; output PROD_W-bit weighted value. It performs sign-extend, +sign, and shift. The FSM and accumulator stay in booth_pp_accumulator.

Test Plan:
- x=3, y=5 (beats: dout=0x00003 s=0 first=1; dout=0x00003 s=0; then six beats dout=0 s=0) -> prod_valid one cycle after 8th beat, prod=0x0000000F, err never set.
- x=-1, y=-1 (beat0 dout=0x00000 s=1 first=1; beats 1..7 dout=0 s=0) -> prod=0x00000001.
- x=0x8000, y=0x8000 (beats 0..6 dout=0 s=0, first on beat0; beat7 dout=0x0FFFF s=1) -> prod=0x40000000.
- Backpressure: complete x=3,y=5 with prod_ready=0 for 5 cycles -> prod holds 0x0000000F, pp_ready=0 throughout. prod_ready=1 -> IDLE next cycle, pp_ready=1.
- Protocol errors: beat with first=0 in IDLE -> err pulses 1 cycle, state stays IDLE. Then first=1 at beat 3 of a product -> err pulse, restart. Eight further correct beats of x=3,y=5 -> prod=0x0000000F.
- rst asserted after 4 beats -> next cycle prod=0, prod_valid=0, pp_ready=1, err=0. A fresh x=-1,y=-1 stream -> prod=0x00000001.
